// File: rtl/fpmul_out_stage.sv
// Registered output stage for the single-precision multiplier: IEEE special-value
// substitution, 2-entry skid buffer, sticky flags. Optional macro FPOUT_EXC_CNT_EN adds exception counters.
module fpmul_out_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_result,
  input  logic             in_overflow,
  input  logic             in_underflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [1:0]       out_flags,
  input  logic             sticky_clr,
  output logic             sticky_ovf,
  output logic             sticky_unf,
  output logic [CNT_W-1:0] acc_count
`ifdef FPOUT_EXC_CNT_EN
  ,
  output logic [CNT_W-1:0] ovf_count,
  output logic [CNT_W-1:0] unf_count
`endif
);

  generate
    if (DEPTH != 2) begin : g_depth_check
      $error("fpmul_out_stage: DEPTH must be 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Overflow dominates underflow; sign is always preserved.
  function automatic logic [31:0] substitute(input logic [31:0] r, input logic ovf, input logic unf);
    if (ovf) begin
      return {r[31], 8'hFF, 23'h000000};
    end else if (unf) begin
      return {r[31], 8'h00, 23'h000000};
    end else begin
      return r;
    end
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_MAX) begin
      return c;
    end else begin
      return c + CNT_ONE;
    end
  endfunction

  state_t            state_r, next_state_s;
  logic              in_ready_r, out_valid_r;
  logic [31:0]       head_res_r, skid_res_r;
  logic [1:0]        head_flg_r, skid_flg_r;
  logic              sticky_ovf_r, sticky_unf_r;
  logic [CNT_W-1:0]  acc_count_r;
  logic              accept_s, pop_s;
  logic              load_head_in_s, load_head_skid_s, load_skid_s;
  logic [31:0]       sub_res_s;
  logic [1:0]        in_flg_s;

  assign accept_s  = in_valid & in_ready_r;
  assign pop_s     = out_valid_r & out_ready;
  assign sub_res_s = substitute(in_result, in_overflow, in_underflow);
  assign in_flg_s  = {in_overflow, in_underflow};

  // Next-state and buffer load selection.
  always_comb begin
    next_state_s     = state_r;
    load_head_in_s   = 1'b0;
    load_head_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          next_state_s   = ONE;
          load_head_in_s = 1'b1;
        end else begin
          next_state_s = EMPTY;
        end
      end
      ONE: begin
        if (accept_s && pop_s) begin
          next_state_s   = ONE;
          load_head_in_s = 1'b1;
        end else if (accept_s) begin
          next_state_s = FULL;
          load_skid_s  = 1'b1;
        end else if (pop_s) begin
          next_state_s = EMPTY;
        end else begin
          next_state_s = ONE;
        end
      end
      FULL: begin
        if (pop_s) begin
          next_state_s     = ONE;
          load_head_skid_s = 1'b1;
        end else begin
          next_state_s = FULL;
        end
      end
      default: begin
        next_state_s = EMPTY;
      end
    endcase
  end

  // State, handshake registers and buffer entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      head_res_r  <= 32'h0000_0000;
      head_flg_r  <= 2'b00;
      skid_res_r  <= 32'h0000_0000;
      skid_flg_r  <= 2'b00;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= (next_state_s != FULL);
      out_valid_r <= (next_state_s != EMPTY);
      if (load_head_in_s) begin
        head_res_r <= sub_res_s;
        head_flg_r <= in_flg_s;
      end else if (load_head_skid_s) begin
        head_res_r <= skid_res_r;
        head_flg_r <= skid_flg_r;
      end
      if (load_skid_s) begin
        skid_res_r <= sub_res_s;
        skid_flg_r <= in_flg_s;
      end
    end
  end

  // Sticky flags (a flagged accept beats a coincident clear) and accept counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_ovf_r <= 1'b0;
      sticky_unf_r <= 1'b0;
      acc_count_r  <= '0;
    end else begin
      if (accept_s && in_overflow) begin
        sticky_ovf_r <= 1'b1;
      end else if (sticky_clr) begin
        sticky_ovf_r <= 1'b0;
      end
      if (accept_s && in_underflow) begin
        sticky_unf_r <= 1'b1;
      end else if (sticky_clr) begin
        sticky_unf_r <= 1'b0;
      end
      if (accept_s) begin
        acc_count_r <= sat_inc(acc_count_r);
      end
    end
  end

`ifdef FPOUT_EXC_CNT_EN
  logic [CNT_W-1:0] ovf_count_r, unf_count_r;

  // Exception counters: clear restarts at 1 when a flagged accept coincides.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_count_r <= '0;
      unf_count_r <= '0;
    end else begin
      if (sticky_clr) begin
        ovf_count_r <= (accept_s && in_overflow) ? CNT_ONE : '0;
        unf_count_r <= (accept_s && in_underflow) ? CNT_ONE : '0;
      end else begin
        if (accept_s && in_overflow) begin
          ovf_count_r <= sat_inc(ovf_count_r);
        end
        if (accept_s && in_underflow) begin
          unf_count_r <= sat_inc(unf_count_r);
        end
      end
    end
  end

  assign ovf_count = ovf_count_r;
  assign unf_count = unf_count_r;
`endif

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_result = head_res_r;
  assign out_flags  = head_flg_r;
  assign sticky_ovf = sticky_ovf_r;
  assign sticky_unf = sticky_unf_r;
  assign acc_count  = acc_count_r;

endmodule

// File: tb/tb_fpmul_out_stage.sv
// Directed self-checking bench for fpmul_out_stage; hand-computed expectations.
module tb_fpmul_out_stage;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [31:0]      in_result;
  logic             in_overflow, in_underflow;
  logic             out_valid, out_ready;
  logic [31:0]      out_result;
  logic [1:0]       out_flags;
  logic             sticky_clr, sticky_ovf, sticky_unf;
  logic [CNT_W-1:0] acc_count;
`ifdef FPOUT_EXC_CNT_EN
  logic [CNT_W-1:0] ovf_count, unf_count;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_acc  = 0;

  fpmul_out_stage #(.DEPTH(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_overflow(in_overflow), .in_underflow(in_underflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
    .sticky_clr(sticky_clr), .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf),
    .acc_count(acc_count)
`ifdef FPOUT_EXC_CNT_EN
    , .ovf_count(ovf_count), .unf_count(unf_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic o, input logic u);
    in_valid = v; in_result = r; in_overflow = o; in_underflow = u;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_acc = 0;
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    out_ready = 1'b0; sticky_clr = 1'b0;
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_result !== 32'h0 || out_flags !== 2'b00) begin failures++; $display("FAIL reset_out got=%h/%b exp=0/00", out_result, out_flags); end
    checks++; if (sticky_ovf !== 1'b0 || sticky_unf !== 1'b0) begin failures++; $display("FAIL reset_sticky got=%b%b exp=00", sticky_ovf, sticky_unf); end
    checks++; if (acc_count !== 16'd0) begin failures++; $display("FAIL reset_acc got=%0d exp=0", acc_count); end
  endtask

  task automatic test_pass();
    out_ready = 1'b1;
    drive(1'b1, 32'h4040_0000, 1'b0, 1'b0);
    step(); exp_acc++;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_result !== 32'h4040_0000) begin failures++; $display("FAIL pass_result got=%b/%h exp=1/40400000", out_valid, out_result); end
    checks++; if (out_flags !== 2'b00) begin failures++; $display("FAIL pass_flags got=%b exp=00", out_flags); end
    checks++; if (acc_count !== 16'd1) begin failures++; $display("FAIL pass_acc got=%0d exp=1", acc_count); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pass_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    drive(1'b1, 32'hC123_4567, 1'b1, 1'b0);
    step(); exp_acc++;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (out_result !== 32'hFF80_0000) begin failures++; $display("FAIL ovf_result got=%h exp=ff800000", out_result); end
    checks++; if (out_flags !== 2'b10) begin failures++; $display("FAIL ovf_flags got=%b exp=10", out_flags); end
    checks++; if (sticky_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", sticky_ovf); end
    step();
    checks++; if (sticky_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky_hold got=%b exp=1", sticky_ovf); end
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    checks++; if (sticky_ovf !== 1'b0) begin failures++; $display("FAIL ovf_sticky_clr got=%b exp=0", sticky_ovf); end
  endtask

  task automatic test_underflow();
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0012, 1'b0, 1'b1);
    step(); exp_acc++;
    checks++; if (out_result !== 32'h0000_0000 || out_flags !== 2'b01) begin failures++; $display("FAIL unf_pos got=%h/%b exp=00000000/01", out_result, out_flags); end
    checks++; if (sticky_unf !== 1'b1) begin failures++; $display("FAIL unf_sticky got=%b exp=1", sticky_unf); end
    drive(1'b1, 32'h8000_0012, 1'b0, 1'b1);
    step(); exp_acc++;
    checks++; if (out_result !== 32'h8000_0000) begin failures++; $display("FAIL unf_neg got=%h exp=80000000", out_result); end
    drive(1'b1, 32'h3F80_0001, 1'b1, 1'b1);
    step(); exp_acc++;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (out_result !== 32'h7F80_0000 || out_flags !== 2'b11) begin failures++; $display("FAIL both_flags got=%h/%b exp=7f800000/11", out_result, out_flags); end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    step(); exp_acc++;
    checks++; if (in_ready !== 1'b1 || out_result !== 32'hAAAA_0001) begin failures++; $display("FAIL b2b_a got=%b/%h exp=1/aaaa0001", in_ready, out_result); end
    drive(1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
    step(); exp_acc++;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full got=%b exp=0", in_ready); end
    drive(1'b1, 32'hCCCC_0003, 1'b0, 1'b0);
    step();
    checks++; if (out_result !== 32'hAAAA_0001 || out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall got=%h/%b/%b exp=aaaa0001/1/0", out_result, out_valid, in_ready); end
    out_ready = 1'b1;
    step();
    checks++; if (out_result !== 32'hBBBB_0002 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_b got=%h/%b exp=bbbb0002/1", out_result, in_ready); end
    step(); exp_acc++;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (out_result !== 32'hCCCC_0003 || out_valid !== 1'b1) begin failures++; $display("FAIL b2b_c got=%h/%b exp=cccc0003/1", out_result, out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    checks++; if (acc_count !== exp_acc[CNT_W-1:0]) begin failures++; $display("FAIL b2b_acc got=%0d exp=%0d", acc_count, exp_acc); end
  endtask

  task automatic test_throughput();
    int outs = 0;
    int bad  = 0;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      drive(1'b1, 32'h3F80_0000 + k, 1'b0, 1'b0);
      step();
      if (out_valid === 1'b1) outs++;
      if (out_result !== 32'h3F80_0000 + k && bad == 0) begin
        bad++;
        $display("FAIL tput_order got=%h exp=%h", out_result, 32'h3F80_0000 + k);
      end
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (bad != 0) failures++;
    checks++; if (outs != 100) begin failures++; $display("FAIL tput_count got=%0d exp=100", outs); end
    checks++; if (acc_count !== 16'd100) begin failures++; $display("FAIL tput_acc got=%0d exp=100", acc_count); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL tput_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    drive(1'b1, 32'h1111_1111, 1'b0, 1'b0);
    step();
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rstf_full got=%b exp=0", in_ready); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rstf_async got=%b/%b exp=0/1", out_valid, in_ready); end
    checks++; if (acc_count !== 16'd0) begin failures++; $display("FAIL rstf_acc got=%0d exp=0", acc_count); end
    step();
    rst = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstf_after got=%b exp=0", out_valid); end
  endtask

  task automatic test_sticky_set_wins();
    out_ready = 1'b1;
    sticky_clr = 1'b1;
    drive(1'b1, 32'h4000_0000, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (sticky_ovf !== 1'b1) begin failures++; $display("FAIL setwins_ovf got=%b exp=1", sticky_ovf); end
`ifdef FPOUT_EXC_CNT_EN
    checks++; if (ovf_count !== 16'd1 || unf_count !== 16'd0) begin failures++; $display("FAIL setwins_cnt got=%0d/%0d exp=1/0", ovf_count, unf_count); end
`endif
    step();
    sticky_clr = 1'b0;
    checks++; if (sticky_ovf !== 1'b0) begin failures++; $display("FAIL setwins_clr got=%b exp=0", sticky_ovf); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_throughput();
    test_reset_full();
    test_sticky_set_wins();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
